uart_prog_ctrl: RTL and testbench

- Sequences the byte stream from the programmable UART receiver into 32-bit instruction-memory writes, so that a program can be loaded over serial at boot.
- Configures the receiver's bit period, assembles little-endian words and issues req/gnt write transactions.
- Recognises an end-of-program marker and reports completion and error status to the boot/reset logic.

---
 rtl/uart_prog_pkg.sv | 19 +
 rtl/uart_prog_word_asm.sv | 116 +++++++++++
 rtl/uart_prog_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_prog_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_pkg.sv
// Shared types and defaults for the UART program loader.
package uart_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned LANE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = LANE_W * BYTES_PER_WORD;
  localparam int unsigned TMO_W          = 20;

  localparam logic [WORD_W-1:0] DEF_END_WORD     = 32'h0000_0FFF;
  localparam logic [15:0]       DEF_CLKS_PER_BIT = 16'd87;

endpackage

// File: rtl/uart_prog_word_asm.sv
// Little-endian byte-to-word assembler with a one-byte skid buffer and
// partial-word timeout. Outputs suffixed _c_o are combinational.
module uart_prog_word_asm
  import uart_prog_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              recv_i,
  input  logic              hold_i,
  input  logic              word_ack_i,
  input  logic              rx_dv_i,
  input  logic [LANE_W-1:0] rx_byte_i,
  output logic              word_valid_c_o,
  output logic [WORD_W-1:0] word_c_o,
  output logic              overrun_c_o,
  output logic              timeout_c_o
);

  localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned FILL_W = IDX_W + 1;

  logic [BYTES_PER_WORD-1:0][LANE_W-1:0] lanes_q, lanes_d, lanes_v;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FILL_W-1:0] fill_v;
  logic [LANE_W-1:0] skid_q, skid_d;
  logic              skid_vld_q, skid_vld_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lanes_q    <= '0;
      idx_q      <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      lanes_q    <= lanes_d;
      idx_q      <= idx_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      tmo_q      <= tmo_d;
    end
  end

  // A pending skid byte always lands ahead of a same-cycle new byte.
  always_comb begin
    lanes_d        = lanes_q;
    idx_d          = idx_q;
    skid_d         = skid_q;
    skid_vld_d     = skid_vld_q;
    tmo_d          = tmo_q;
    lanes_v        = lanes_q;
    fill_v         = {1'b0, idx_q};
    word_valid_c_o = 1'b0;
    overrun_c_o    = 1'b0;
    timeout_c_o    = 1'b0;

    if (start_i) begin
      lanes_d    = '0;
      idx_d      = '0;
      skid_d     = '0;
      skid_vld_d = 1'b0;
      tmo_d      = '0;
    end else if (recv_i) begin
      if (skid_vld_q) begin
        lanes_v[fill_v[IDX_W-1:0]] = skid_q;
        fill_v                     = fill_v + FILL_W'(1);
        skid_vld_d                 = 1'b0;
      end
      if (rx_dv_i) begin
        lanes_v[fill_v[IDX_W-1:0]] = rx_byte_i;
        fill_v                     = fill_v + FILL_W'(1);
      end

      if (fill_v == FILL_W'(BYTES_PER_WORD)) begin
        word_valid_c_o = 1'b1;
        lanes_d        = '0;
        idx_d          = '0;
        tmo_d          = '0;
      end else if (skid_vld_q || rx_dv_i) begin
        lanes_d = lanes_v;
        idx_d   = fill_v[IDX_W-1:0];
        tmo_d   = '0;
      end else if (idx_q == '0) begin
        tmo_d = '0;
      end else if (tmo_q == TIMEOUT_CYC - TMO_W'(1)) begin
        timeout_c_o = 1'b1;
        lanes_d     = '0;
        idx_d       = '0;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else if (hold_i) begin
      if (rx_dv_i) begin
        if (skid_vld_q) begin
          overrun_c_o = 1'b1;
        end else begin
          skid_d     = rx_byte_i;
          skid_vld_d = 1'b1;
        end
      end
      if (word_ack_i) begin
        lanes_d = '0;
        idx_d   = '0;
        tmo_d   = '0;
      end
    end
  end

  assign word_c_o = lanes_v;

endmodule

// File: rtl/uart_prog_ctrl.sv
// Boot-time program loader: turns UART bytes into 32-bit memory writes
// until the end-of-program marker word is received.
module uart_prog_ctrl
  import uart_prog_pkg::*;
#(
  parameter int unsigned        ADDR_W           = 14,
  parameter logic [WORD_W-1:0]  END_WORD         = DEF_END_WORD,
  parameter logic [15:0]        CLKS_PER_BIT_DEF = DEF_CLKS_PER_BIT,
  parameter logic [TMO_W-1:0]   TIMEOUT_CYC      = 20'd1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [15:0]       clks_per_bit_o,
  input  logic              rx_dv_i,
  input  logic [LANE_W-1:0] rx_byte_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-2:0] word_cnt_o,
  output logic              err_overrun_o,
  output logic              err_timeout_o
);

  localparam int unsigned CNT_W = ADDR_W - 1;

  state_e            state_q, state_d;
  logic              mem_req_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_ovr_q, err_ovr_d;
  logic              err_tmo_q, err_tmo_d;
  logic              start_c, ack_c;
  logic              word_valid_c, overrun_c, timeout_c;
  logic [WORD_W-1:0] word_c;

  uart_prog_word_asm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_word_asm (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_c),
    .recv_i         (state_q == ST_RECV),
    .hold_i         (state_q == ST_WRITE),
    .word_ack_i     (ack_c),
    .rx_dv_i        (rx_dv_i),
    .rx_byte_i      (rx_byte_i),
    .word_valid_c_o (word_valid_c),
    .word_c_o       (word_c),
    .overrun_c_o    (overrun_c),
    .timeout_c_o    (timeout_c)
  );

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      err_ovr_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == ST_WRITE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      err_ovr_q <= err_ovr_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_ovr_d = err_ovr_q;
    err_tmo_d = err_tmo_q;
    start_c   = 1'b0;
    ack_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d   = ST_RECV;
          start_c   = 1'b1;
          addr_d    = '0;
          cnt_d     = '0;
          err_ovr_d = 1'b0;
          err_tmo_d = 1'b0;
        end
      end
      ST_RECV: begin
        if (word_valid_c) begin
          if (word_c == END_WORD) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
            wdata_d = word_c;
          end
        end
      end
      ST_WRITE: begin
        if (mem_gnt_i) begin
          ack_c   = 1'b1;
          addr_d  = addr_q + ADDR_W'(BYTES_PER_WORD);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_RECV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (overrun_c) err_ovr_d = 1'b1;
    if (timeout_c) err_tmo_d = 1'b1;
  end

  assign clks_per_bit_o = CLKS_PER_BIT_DEF;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_req_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign word_cnt_o     = cnt_q;
  assign err_overrun_o  = err_ovr_q;
  assign err_timeout_o  = err_tmo_q;

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Bench for uart_prog_ctrl: a wide-address and a 4-bit-address instance share
// stimulus; expected writes come from grouping the sent bytes into words.
module tb_uart_prog_ctrl;

  localparam logic [31:0] END_W = 32'h0000_0FFF;

  logic        clk = 1'b0;
  logic        rst_i, en_i, rx_dv_i, mem_gnt_i;
  logic [7:0]  rx_byte_i;

  logic [15:0] cpb, w_cpb;
  logic        req, we, busy, done, ovr, tmo;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic [12:0] wcnt;
  logic        w_req, w_we, w_busy, w_done, w_ovr, w_tmo;
  logic [3:0]  w_addr_o;
  logic [31:0] w_wdata;
  logic [2:0]  w_wcnt;

  uart_prog_ctrl #(.ADDR_W(14), .TIMEOUT_CYC(20'd100)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clks_per_bit_o(cpb),
    .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i), .mem_req_o(req), .mem_we_o(we),
    .mem_addr_o(addr), .mem_wdata_o(wdata), .mem_gnt_i(mem_gnt_i),
    .busy_o(busy), .done_o(done), .word_cnt_o(wcnt),
    .err_overrun_o(ovr), .err_timeout_o(tmo)
  );

  uart_prog_ctrl #(.ADDR_W(4), .TIMEOUT_CYC(20'd100)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clks_per_bit_o(w_cpb),
    .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i), .mem_req_o(w_req), .mem_we_o(w_we),
    .mem_addr_o(w_addr_o), .mem_wdata_o(w_wdata), .mem_gnt_i(mem_gnt_i),
    .busy_o(w_busy), .done_o(w_done), .word_cnt_o(w_wcnt),
    .err_overrun_o(w_ovr), .err_timeout_o(w_tmo)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [13:0] act_addr[$];
  logic [31:0] act_data[$];
  logic [3:0]  w_addr[$];
  logic [31:0] w_data[$];
  int          done_seen = 0;
  int          w_done_seen = 0;
  int          we_bad = 0;

  logic [31:0] exp_data[$];
  int          a_base, w_base, d_base, wd_base;

  // Write monitor: a transfer completes at the edge after req && gnt is seen.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (req && mem_gnt_i) begin
        act_addr.push_back(addr);
        act_data.push_back(wdata);
      end
      if (w_req && mem_gnt_i) begin
        w_addr.push_back(w_addr_o);
        w_data.push_back(w_wdata);
      end
      if (done) done_seen++;
      if (w_done) w_done_seen++;
      if (we !== req || w_we !== w_req) we_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte_i = b;
    rx_dv_i   = 1'b1;
    tick();
    rx_dv_i   = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], int'($urandom_range(max_gap, 0)));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == END_W) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic start_load();
    a_base = act_addr.size();
    d_base = done_seen;
    w_base = w_addr.size();
    wd_base = w_done_seen;
    exp_data.delete();
    en_i = 1'b1;
    tick();
    en_i = 1'b0;
  endtask

  task automatic check_load(input string tag, input logic e_ovr, input logic e_tmo);
    int n;
    n = exp_data.size();
    chk({tag, "_nwr"}, 64'(act_addr.size() - a_base), 64'(n));
    chk({tag, "_w_nwr"}, 64'(w_addr.size() - w_base), 64'(n));
    for (int k = 0; k < n; k++) begin
      logic [63:0] oa, od, owa, owd;
      oa = 'x; od = 'x; owa = 'x; owd = 'x;
      if (a_base + k < act_addr.size()) begin
        oa = 64'(act_addr[a_base + k]);
        od = 64'(act_data[a_base + k]);
      end
      if (w_base + k < w_addr.size()) begin
        owa = 64'(w_addr[w_base + k]);
        owd = 64'(w_data[w_base + k]);
      end
      chk($sformatf("%s_addr%0d", tag, k), oa, 64'((k * 4) % 16384));
      chk($sformatf("%s_data%0d", tag, k), od, 64'(exp_data[k]));
      chk($sformatf("%s_waddr%0d", tag, k), owa, 64'((k * 4) % 16));
      chk($sformatf("%s_wdata%0d", tag, k), owd, 64'(exp_data[k]));
    end
    chk({tag, "_done"}, 64'(done_seen - d_base), 64'(1));
    chk({tag, "_w_done"}, 64'(w_done_seen - wd_base), 64'(1));
    chk({tag, "_cnt"}, 64'(wcnt), 64'(n % 8192));
    chk({tag, "_w_cnt"}, 64'(w_wcnt), 64'(n % 8));
    chk({tag, "_ovr"}, 64'({ovr, w_ovr}), 64'({e_ovr, e_ovr}));
    chk({tag, "_tmo"}, 64'({tmo, w_tmo}), 64'({e_tmo, e_tmo}));
    chk({tag, "_busy"}, 64'({busy, w_busy, req}), 64'(0));
  endtask

  task automatic run_random(input string tag, input int n_words, input int max_gap);
    logic [31:0] w;
    mem_gnt_i = 1'b1;
    start_load();
    for (int k = 0; k < n_words; k++) begin
      w = rand_word();
      exp_data.push_back(w);
      send_word(w, max_gap);
    end
    send_word(END_W, max_gap);
    repeat (3) tick();
    check_load(tag, 1'b0, 1'b0);
  endtask

  // Holds a write stalled for 50 cycles, injecting bytes at cycles 10 and (optionally) 20.
  task automatic stall_test(input string tag, input logic second_byte);
    logic [31:0] wa, wb;
    logic [7:0]  dropped;
    int          bad;
    wa = rand_word();
    wb = rand_word();
    dropped = wb[15:8] ^ 8'h5A;
    bad = 0;
    mem_gnt_i = 1'b0;
    start_load();
    exp_data.push_back(wa);
    exp_data.push_back(wb);
    send_word(wa, 0);
    for (int i = 0; i < 50; i++) begin
      rx_dv_i   = (i == 10) || (second_byte && i == 20);
      rx_byte_i = (i == 10) ? wb[7:0] : dropped;
      @(negedge clk);
      if (!(req === 1'b1 && addr === 14'h0 && wdata === wa)) bad++;
      tick();
    end
    rx_dv_i = 1'b0;
    chk({tag, "_stable"}, 64'(bad), 64'(0));
    chk({tag, "_ovr_mid"}, 64'(ovr), 64'(second_byte));
    mem_gnt_i = 1'b1;
    tick();
    for (int b = 1; b < 4; b++) send_byte(wb[8*b +: 8], 0);
    send_word(END_W, 0);
    repeat (3) tick();
    check_load(tag, second_byte, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w1, w2;
    rst_i = 1'b1; en_i = 1'b0; rx_dv_i = 1'b0; rx_byte_i = '0; mem_gnt_i = 1'b0;
    repeat (3) tick();
    chk("rst_req", 64'({req, w_req}), 64'(0));
    chk("rst_busy_done", 64'({busy, done, w_busy, w_done}), 64'(0));
    chk("rst_addr", 64'({addr, w_addr_o}), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_cnt", 64'({wcnt, w_wcnt}), 64'(0));
    chk("rst_err", 64'({ovr, tmo, w_ovr, w_tmo}), 64'(0));
    chk("cpb", 64'({cpb, w_cpb}), 64'({16'd87, 16'd87}));
    rst_i = 1'b0;
    tick();

    // Bytes in IDLE must be ignored.
    mem_gnt_i = 1'b1;
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 1);
    chk("idle_quiet", 64'({busy, req}), 64'(0));

    // Two-word directed load.
    start_load();
    chk("busy_recv", 64'(busy), 64'(1));
    exp_data.push_back(32'h1234_5678);
    exp_data.push_back(32'hDEAD_BEEF);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(END_W, 0);
    repeat (3) tick();
    check_load("two_words", 1'b0, 1'b0);

    stall_test("stall", 1'b0);
    stall_test("overrun", 1'b1);

    // 99 idle cycles inside a word is still within budget.
    mem_gnt_i = 1'b1;
    start_load();
    chk("start_clears_ovr", 64'(ovr), 64'(0));
    exp_data.push_back(32'hDDCC_BBAA);
    send_byte(8'hAA, 0); send_byte(8'hBB, 99);
    send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    send_word(END_W, 0);
    repeat (3) tick();
    check_load("tmo_edge", 1'b0, 1'b0);

    // 100 idle cycles discards the partial word.
    start_load();
    exp_data.push_back(32'h0000_0001);
    send_byte(8'h11, 0); send_byte(8'h22, 100);
    chk("tmo_flag", 64'({tmo, w_tmo}), 64'(2'b11));
    send_word(32'h0000_0001, 0);
    send_word(END_W, 0);
    repeat (3) tick();
    check_load("timeout", 1'b0, 1'b1);

    // Reset while a write is stalled.
    w1 = rand_word();
    w2 = rand_word();
    start_load();
    send_word(w1, 0);
    repeat (2) tick();
    mem_gnt_i = 1'b0;
    send_word(w2, 0);
    chk("pre_rst_req", 64'({req, addr}), 64'({1'b1, 14'h4}));
    rst_i = 1'b1;
    tick();
    chk("mid_rst_req", 64'({req, w_req}), 64'(0));
    chk("mid_rst_busy", 64'({busy, w_busy}), 64'(0));
    chk("mid_rst_addr", 64'(addr), 64'(0));
    chk("mid_rst_cnt", 64'(wcnt), 64'(0));
    chk("mid_rst_err", 64'({ovr, tmo}), 64'(0));
    rst_i = 1'b0;
    tick();

    run_random("after_rst", 3, 2);
    run_random("wrap5", 5, 3);
    run_random("wrap9", 9, 1);
    chk("we_eq_req", 64'(we_bad), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
